// File: rtl/wisc_mem_pkg.sv
// wisc_mem_pkg: shared FSM state type and default sizing for the data-memory controller
package wisc_mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_LATENCY = 4;
endpackage

// File: rtl/lat_counter.sv
// lat_counter: loadable down-counter that holds at zero and flags it
module lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);
  logic [W-1:0] r_count;
  // load takes priority over decrement; the count never wraps below zero
  always_ff @(posedge clk)
    if (!rst_n) r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_dec && r_count != '0) r_count <= r_count - 1'b1;
  assign o_zero = r_count == '0;
endmodule

// File: rtl/data_mem_controller.sv
// data_mem_controller: multi-cycle data-memory access sequencer that stalls the pipeline
module data_mem_controller
  import wisc_mem_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_mem_access,
  input  logic              mem_we_req,
  input  logic [ADDR_W-1:0] mem_addr_req,
  input  logic [DATA_W-1:0] mem_wdata_req,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  state_t            r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_done;
  logic              w_accept;
  logic              w_busy;
  logic              w_zero;
  assign w_busy   = r_state == BUSY;
  assign w_accept = r_state == IDLE && data_mem_access;
  lat_counter #(.W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_dec      (w_busy),
    .i_load_val (CNT_W'(LATENCY - 1)),
    .o_zero     (w_zero)
  );
  assign stall     = rst_n && (w_accept || w_busy);
  assign mem_en    = rst_n && w_busy;
  assign mem_we    = mem_en && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rdata     = r_rdata;
  assign done      = r_done;
  // request latch, access sequencing and load-data capture
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (data_mem_access) begin
          r_state <= BUSY;
          r_we    <= mem_we_req;
          r_addr  <= mem_addr_req;
          r_wdata <= mem_wdata_req;
        end
        BUSY: if (w_zero) begin
          r_state <= DONE;
          r_done  <= 1'b1;
          if (!r_we) r_rdata <= mem_rdata;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_data_mem_controller.sv
// tb_data_mem_controller: randomized and directed checks against a timeline model of the access protocol
module tb_data_mem_controller;
  localparam int LAT = 4;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        acc = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] mrd = '0;
  logic        stall, done, mem_en, mem_we;
  logic [15:0] rdata, mem_addr, mem_wdata;
  logic        acc1 = 1'b0;
  logic        we1 = 1'b0;
  logic [15:0] addr1 = '0;
  logic [15:0] wdata1 = '0;
  logic [15:0] mrd1 = '0;
  logic        stall1, done1, mem_en1, mem_we1;
  logic [15:0] rdata1, mem_addr1, mem_wdata1;
  int checks = 0;
  int errors = 0;

  data_mem_controller #(.DATA_W(16), .ADDR_W(16), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .data_mem_access(acc), .mem_we_req(we),
    .mem_addr_req(addr), .mem_wdata_req(wdata), .stall(stall), .done(done),
    .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mrd)
  );

  data_mem_controller #(.DATA_W(16), .ADDR_W(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .data_mem_access(acc1), .mem_we_req(we1),
    .mem_addr_req(addr1), .mem_wdata_req(wdata1), .stall(stall1), .done(done1),
    .rdata(rdata1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mrd1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an accepted request at edge number acc_e owns the next LAT cycles
  // as memory access, then one done cycle, then the controller is free again.
  int          n = 0;
  int          acc_e = -1000;
  bit          m_act = 1'b0;
  bit          cmp_en = 1'b0;
  logic        m_we = 1'b0;
  logic [15:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] m_rdata = '0;

  function automatic bit m_busy();
    return m_act && (n - acc_e) >= 0 && (n - acc_e) < LAT;
  endfunction
  function automatic bit m_dn();
    return m_act && (n - acc_e) == LAT;
  endfunction
  function automatic bit m_idle();
    return !m_busy() && !m_dn();
  endfunction

  task automatic model_edge();
    bit idle_b;
    idle_b = m_idle();
    n++;
    if (!rst_n) begin
      m_act = 1'b0;
      m_we = 1'b0;
      m_addr = '0;
      m_wdata = '0;
      m_rdata = '0;
    end else begin
      if (m_act && (n - acc_e) == LAT && !m_we) m_rdata = mrd;
      if (idle_b && acc) begin
        m_act = 1'b1;
        acc_e = n;
        m_we = we;
        m_addr = addr;
        m_wdata = wdata;
      end
    end
    cmp_en = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin : cmp
    bit b;
    if (cmp_en) begin
      b = m_busy();
      chk("stall", stall, rst_n && ((m_idle() && acc) || b));
      chk("done", done, m_dn());
      chk("mem_en", mem_en, rst_n && b);
      chk("mem_we", mem_we, rst_n && b && m_we);
      chk("rdata", rdata, m_rdata);
      if (b) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
      end
    end
  end

  task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                        input logic [15:0] rd, input bit flip,
                        output int ns, output int ne, output int nw, output int dc,
                        output logic [15:0] a4);
    ns = 0; ne = 0; nw = 0; dc = 0; a4 = '0;
    we = w; addr = a; wdata = d; mrd = rd; acc = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      ns += int'(stall);
      ne += int'(mem_en);
      nw += int'(mem_we);
      if (done && dc == 0) dc = i;
      if (i == 4) a4 = mem_addr;
      tick();
      if (i == 1) acc = 1'b0;
      if (flip && i == 2) addr = 16'hFFFF;
    end
  endtask

  initial begin
    int ns, ne, nw, dc;
    logic [15:0] a4;
    tick();
    acc = 1'b1;
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_done", done, 0);
    tick();
    acc = 1'b0;
    rst_n = 1'b1;
    tick();
    do_req(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, ns, ne, nw, dc, a4);
    chk("load_stall_cycles", ns, 5);
    chk("load_en_cycles", ne, 4);
    chk("load_done_cycle", dc, 6);
    chk("load_rdata", rdata, 16'hBEEF);
    do_req(1'b1, 16'h0020, 16'h1234, 16'h7777, 1'b0, ns, ne, nw, dc, a4);
    chk("store_we_cycles", nw, 4);
    chk("store_a4", a4, 16'h0020);
    chk("store_keeps_rdata", rdata, 16'hBEEF);
    do_req(1'b0, 16'h0001, 16'h0000, 16'h1111, 1'b0, ns, ne, nw, dc, a4);
    chk("b2b1_stall", ns, 5);
    chk("b2b1_done", dc, 6);
    chk("b2b1_rdata", rdata, 16'h1111);
    do_req(1'b0, 16'h0002, 16'h0000, 16'h2222, 1'b0, ns, ne, nw, dc, a4);
    chk("b2b2_stall", ns, 5);
    chk("b2b2_done", dc, 6);
    chk("b2b2_rdata", rdata, 16'h2222);
    do_req(1'b0, 16'h0010, 16'h0000, 16'h3333, 1'b1, ns, ne, nw, dc, a4);
    chk("addr_hold", a4, 16'h0010);
    we = 1'b0; addr = 16'h0040; mrd = 16'h5555; acc = 1'b1;
    tick();
    acc = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_stall", stall, 0);
    chk("abort_rdata", rdata, 0);
    chk("abort_mem_en", mem_en, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      tick();
    end
    do_req(1'b0, 16'h0050, 16'h0000, 16'h6666, 1'b0, ns, ne, nw, dc, a4);
    chk("post_rst_stall", ns, 5);
    chk("post_rst_done", dc, 6);
    chk("post_rst_rdata", rdata, 16'h6666);
    for (int i = 0; i < 400; i++) begin
      acc = 1'($urandom);
      we = 1'($urandom);
      addr = 16'($urandom);
      wdata = 16'($urandom);
      mrd = 16'($urandom);
      rst_n = $urandom_range(0, 39) != 0;
      tick();
    end
    rst_n = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    ns = 0; dc = 0;
    acc1 = 1'b1; mrd1 = 16'hA5A5;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      ns += int'(stall1);
      if (done1 && dc == 0) dc = i;
      tick();
      if (i == 1) acc1 = 1'b0;
    end
    chk("lat1_stall", ns, 2);
    chk("lat1_done", dc, 3);
    chk("lat1_rdata", rdata1, 16'hA5A5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_controller.md
DATA_MEM_CONTROLLER -- requirements
Module: data_mem_controller

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_W, 16, data width
  ADDR_W, 16, word address width
  LATENCY, 4, memory access cycles (>=1)
REQ-002 Ports SHALL be, one per line, clock and reset first:
  clk  input  1  single clock; all logic on posedge
  rst_n  input  1  synchronous, active-low reset
  data_mem_access  input  1  MEM-stage request
  mem_we_req  input  1  1=store, 0=load
  mem_addr_req  input  ADDR_W  request address
  mem_wdata_req  input  DATA_W  store data
  stall  output  1  freeze pipeline while 1
  done  output  1  one-cycle access-complete pulse
  rdata  output  DATA_W  load result
  mem_en  output  1  memory enable
  mem_we  output  1  memory write enable
  mem_addr  output  ADDR_W  memory address
  mem_wdata  output  DATA_W  memory write data
  mem_rdata  input  DATA_W  memory read data
REQ-003 There SHALL be one clock (clk); reset SHALL be synchronous and active-low (rst_n).

Function
REQ-004 FSM states SHALL be IDLE, BUSY and DONE.
REQ-005 IDLE: data_mem_access=1 at a posedge SHALL latch mem_we_req, mem_addr_req and mem_wdata_req, load the cycle counter with LATENCY-1 and go to BUSY; otherwise stay in IDLE.
REQ-006 BUSY: mem_en=1; mem_we, mem_addr and mem_wdata SHALL come from the latched values and be stable for all LATENCY cycles.
REQ-007 BUSY: the counter SHALL decrement each cycle; at counter==0 the FSM SHALL go to DONE, and on that edge rdata SHALL capture mem_rdata if the access is a load.
REQ-008 DONE: done=1 and stall=0 for exactly one cycle; data_mem_access SHALL be ignored; the next state SHALL be IDLE.
REQ-009 stall SHALL be combinational: (IDLE & data_mem_access) | BUSY, and 0 in DONE.
REQ-010 A request SHALL therefore see stall high for LATENCY+1 cycles, then done high for 1 cycle; the pipeline advances on the DONE edge.
REQ-011 Request inputs SHALL be ignored outside IDLE; changes during BUSY SHALL NOT affect the memory outputs.
REQ-012 Stores SHALL leave rdata unchanged; rdata SHALL hold its value until the next load completes.
REQ-013 Back-to-back requests SHALL each require a pass through IDLE; a request present in the cycle after DONE SHALL be accepted normally.
REQ-014 mem_en=0 and mem_we=0 in IDLE and DONE.
REQ-015 The counter width SHALL be max(1, clog2(LATENCY)); LATENCY=1 SHALL give one BUSY cycle.

Reset
REQ-016 rst_n=0 at a posedge SHALL force IDLE, counter=0, latched request=0, rdata=0 and done=0.
REQ-017 While rst_n=0, stall, mem_en and mem_we SHALL be 0 regardless of data_mem_access.
REQ-018 Reset in BUSY SHALL abort the access with no rdata update; the first request after reset SHALL take the full LATENCY.

Structure
REQ-019 Package wisc_mem_pkg SHALL hold the state enum (IDLE/BUSY/DONE) and the default DATA_W, ADDR_W and LATENCY constants.
REQ-020 One sub-module SHALL exist: lat_counter (loadable down-counter with zero flag); all other logic SHALL be inline.

Verification
REQ-021 Load, LATENCY=4: addr=0x0010, mem_rdata=0xBEEF -> stall high 5 cycles, mem_en high cycles 2-5, done pulse cycle 6, rdata=0xBEEF.
REQ-022 Store: addr=0x0020, wdata=0x1234 -> mem_we=1 for 4 cycles with stable addr/wdata; rdata keeps its prior value 0xBEEF.
REQ-023 Back-to-back loads (0x0001, 0x0002) -> each gets 5 stall cycles and 1 done cycle; rdata updates in order.
REQ-024 Change mem_addr_req to 0xFFFF mid-BUSY -> mem_addr stays 0x0010.
REQ-025 rst_n low in the 2nd BUSY cycle -> next cycle IDLE, stall=0, rdata=0, no done pulse.
REQ-026 LATENCY=1 build -> stall 2 cycles, done on cycle 3.
